eq_compare_pipe: RTL and testbench



---
 rtl/eq_compare_pipe_pkg.sv | 15 +
 rtl/eq_compare_pipe_if.sv | 30 +++
 rtl/eq_chunk_reduce.sv | 24 ++
 rtl/eq_compare_pipe.sv | 106 ++++++++++
 tb/tb_eq_compare_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_compare_pipe_pkg.sv
// eq_cmp_pkg: shared sizing helpers for the masked equality comparator.
// No ports; imported by the interface, the chunk reducer and the top.
package eq_cmp_pkg;

  localparam int PIPE_STAGES = 2;

  function automatic int n_chunk(int w, int s);
    return (w + s - 1) / s;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eq_compare_pipe_if.sv
// eq_compare_pipe_if: operand input and result output handshakes.
// master drives operands/out_ready; slave (the comparator) drives results.
interface eq_compare_pipe_if
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDXW  = idx_w(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic             z;
  logic [IDXW-1:0]  first_diff;

  modport master (
    output in_valid, x, y, mask, out_ready,
    input  in_ready, out_valid, z, first_diff
  );

  modport slave (
    input  in_valid, x, y, mask, out_ready,
    output in_ready, out_valid, z, first_diff
  );

endinterface

// File: rtl/eq_chunk_reduce.sv
// eq_chunk_reduce: AND-reduce one chunk of bit-equal flags and locate
// the lowest clear flag. Ports: e in, ceq out, cidx out (0 if none).
module eq_chunk_reduce
  import eq_cmp_pkg::*;
#(
  parameter int STAGE_BITS = 8,
  parameter int CIW        = idx_w(STAGE_BITS)
) (
  input  logic [STAGE_BITS-1:0] e,
  output logic                  ceq,
  output logic [CIW-1:0]        cidx
);

  assign ceq = &e;

  // Scan downward so the lowest clear bit is the last one written.
  always_comb begin
    cidx = '0;
    for (int i = STAGE_BITS - 1; i >= 0; i--) begin
      if (!e[i]) cidx = CIW'(i);
    end
  end

endmodule

// File: rtl/eq_compare_pipe.sv
// eq_compare_pipe: two-stage masked equality compare with valid/ready.
// Ports: clk, rst (sync, active-high), bus (eq_compare_pipe_if.slave);
// with MATCH_COUNT_EN defined also cnt_clr in, match_cnt out.
module eq_compare_pipe
  import eq_cmp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  eq_compare_pipe_if.slave bus
`ifdef MATCH_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int NCHUNK = n_chunk(WIDTH, STAGE_BITS);
  localparam int IDXW   = idx_w(WIDTH);
  localparam int CIW    = idx_w(STAGE_BITS);
  localparam int PADW   = NCHUNK * STAGE_BITS;

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

  logic                       v1, v2;
  logic                       advance;
  logic [PADW-1:0]            e;
  logic [NCHUNK-1:0]          ceq_d, ceq_q;
  logic [NCHUNK-1:0][CIW-1:0] cidx_d, cidx_q;
  logic                       z_d, z_q;
  logic [IDXW-1:0]            fd_d, fd_q;

  // Pad bits above WIDTH count as equal so they never report.
  always_comb begin
    e = '1;
    e[WIDTH-1:0] = ~bus.mask | ~(bus.x ^ bus.y);
  end

  for (genvar c = 0; c < NCHUNK; c++) begin : g_chunk
    eq_chunk_reduce #(
      .STAGE_BITS(STAGE_BITS)
    ) u_red (
      .e    (e[c*STAGE_BITS +: STAGE_BITS]),
      .ceq  (ceq_d[c]),
      .cidx (cidx_d[c])
    );
  end

  always_comb begin
    z_d  = &ceq_q;
    fd_d = '0;
    for (int c = NCHUNK - 1; c >= 0; c--) begin
      if (!ceq_q[c])
        fd_d = IDXW'(c * STAGE_BITS + int'(cidx_q[c]));
    end
  end

  assign advance      = ~v2 | bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      ceq_q  <= '0;
      cidx_q <= '0;
      z_q    <= 1'b0;
      fd_q   <= '0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      if (bus.in_valid) begin
        ceq_q  <= ceq_d;
        cidx_q <= cidx_d;
      end
      if (v1) begin
        z_q  <= z_d;
        fd_q <= fd_d;
      end
    end
  end

  assign bus.out_valid  = v2;
  assign bus.z          = z_q;
  assign bus.first_diff = fd_q;

`ifdef MATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      match_cnt <= '0;
    else if (cnt_clr)
      match_cnt <= '0;
    else if (v2 && bus.out_ready && z_q && !(&match_cnt))
      match_cnt <= match_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_eq_compare_pipe.sv
// tb_eq_compare_pipe: vector table, directed corner cases and random
// traffic against a queue-based reference for eq_compare_pipe.
module tb_eq_compare_pipe;
  import eq_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_compare_pipe_if #(.WIDTH(32)) b32 ();
  eq_compare_pipe_if #(.WIDTH(30)) b30 ();

`ifdef MATCH_COUNT_EN
  logic        clr32 = 1'b0;
  logic        clr30 = 1'b0;
  logic [15:0] cnt32;
  logic [1:0]  cnt30;
`endif

  eq_compare_pipe #(
    .WIDTH(32), .STAGE_BITS(8), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b32)
`ifdef MATCH_COUNT_EN
    ,
    .cnt_clr   (clr32),
    .match_cnt (cnt32)
`endif
  );

  eq_compare_pipe #(
    .WIDTH(30), .STAGE_BITS(8), .CNT_W(2)
  ) dut30 (
    .clk (clk),
    .rst (rst),
    .bus (b30)
`ifdef MATCH_COUNT_EN
    ,
    .cnt_clr   (clr30),
    .match_cnt (cnt30)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       z;
    logic [4:0] fd;
  } res_t;

  // Lowest differing masked bit, found by isolating the lowest set bit.
  function automatic res_t ref_cmp(logic [31:0] a, logic [31:0] b,
                                   logic [31:0] m, int w);
    logic [31:0] d;
    logic [31:0] lb;
    res_t r;
    d = (a ^ b) & m;
    if (w < 32) d = d & ((32'h1 << w) - 32'h1);
    r.z  = (d == 32'h0);
    r.fd = 5'd0;
    if (!r.z) begin
      lb = d & (~d + 32'h1);
      while (lb > 32'h1) begin
        lb = lb >> 1;
        r.fd = r.fd + 5'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_y(logic [31:0] a);
    case ($urandom_range(0, 2))
      0:       return a;
      1:       return a ^ (32'h1 << $urandom_range(0, 31));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rnd_m();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  res_t q[$];
  res_t mr;
  int   outs = 0;
`ifdef MATCH_COUNT_EN
  logic [15:0] exp_cnt = 16'h0;
  logic        hit;
`endif

  // Monitor: transfers are decided at the next rising edge, and all
  // inputs are stable at the falling edge, so sample there.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
`ifdef MATCH_COUNT_EN
      exp_cnt = 16'h0;
`endif
    end else begin
`ifdef MATCH_COUNT_EN
      chk("match_cnt", 32'(cnt32), 32'(exp_cnt));
      hit = 1'b0;
`endif
      if (b32.out_valid && b32.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got z=%0b want no output",
                   b32.z);
        end else begin
          mr = q.pop_front();
          chk("z", 32'(b32.z), 32'(mr.z));
          chk("first_diff", 32'(b32.first_diff), 32'(mr.fd));
          outs++;
`ifdef MATCH_COUNT_EN
          hit = mr.z;
`endif
        end
      end
      if (b32.in_valid && b32.in_ready)
        q.push_back(ref_cmp(b32.x, b32.y, b32.mask, 32));
`ifdef MATCH_COUNT_EN
      if (clr32) exp_cnt = 16'h0;
      else if (hit && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send30(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m, input string nm);
    res_t r;
    r = ref_cmp(a, b, m, 30);
    b30.x = a[29:0];
    b30.y = b[29:0];
    b30.mask = m[29:0];
    b30.in_valid = 1'b1;
    step();
    b30.in_valid = 1'b0;
    step();
    chk({nm, "_valid"}, 32'(b30.out_valid), 32'h1);
    chk({nm, "_z"}, 32'(b30.z), 32'(r.z));
    chk({nm, "_fd"}, 32'(b30.first_diff), 32'(r.fd));
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] m;
    logic        z;
    logic [4:0]  fd;
  } vec_t;

  vec_t tv[10];
  logic [31:0] sx[8], sy[8], sm[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 5'd0};
    tv[1] = '{32'h00010000, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd16};
    tv[2] = '{32'h00010000, 32'h0, 32'hFFFEFFFF, 1'b1, 5'd0};
    tv[3] = '{32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 5'd0};
    tv[4] = '{32'h00000001, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd0};
    tv[5] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd31};
    tv[6] = '{32'h00000F00, 32'h0, 32'h00000E00, 1'b0, 5'd9};
    tv[7] = '{32'h12345678, 32'h12345678, 32'h0, 1'b1, 5'd0};
    tv[8] = '{32'hFF000000, 32'h0, 32'h0F000000, 1'b0, 5'd24};
    tv[9] = '{32'h00800080, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd7};

    b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    b32.x = '0; b32.y = '0; b32.mask = '0;
    b30.in_valid = 1'b0; b30.out_ready = 1'b1;
    b30.x = '0; b30.y = '0; b30.mask = '0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(b32.out_valid), 32'h0);
    chk("rst_z", 32'(b32.z), 32'h0);
    chk("rst_fd", 32'(b32.first_diff), 32'h0);
    chk("rst_in_ready", 32'(b32.in_ready), 32'h1);
`ifdef MATCH_COUNT_EN
    chk("rst_cnt", 32'(cnt32), 32'h0);
`endif
    rst = 1'b0;
    b32.out_ready = 1'b1;

    // Vector table, one pulse each, result two cycles later
    for (int i = 0; i < 10; i++) begin
      b32.x = tv[i].x; b32.y = tv[i].y; b32.mask = tv[i].m;
      b32.in_valid = 1'b1;
      step();
      b32.in_valid = 1'b0;
      chk($sformatf("tv%0d_lat1", i), 32'(b32.out_valid), 32'h0);
      step();
      chk($sformatf("tv%0d_lat2", i), 32'(b32.out_valid), 32'h1);
      chk($sformatf("tv%0d_z", i), 32'(b32.z), 32'(tv[i].z));
      chk($sformatf("tv%0d_fd", i), 32'(b32.first_diff), 32'(tv[i].fd));
    end

    // Back-to-back stream: 8 results on consecutive cycles
    for (int i = 0; i < 10; i++) begin
      b32.in_valid = (i < 8);
      b32.x = $urandom();
      b32.y = rnd_y(b32.x);
      b32.mask = rnd_m();
      step();
      chk($sformatf("stream_v%0d", i), 32'(b32.out_valid),
          32'((i >= 1) && (i <= 8)));
    end
    b32.in_valid = 1'b0;

    // Stream with out_ready low for three cycles mid-way
    for (int i = 0; i < 8; i++) begin
      sx[i] = $urandom(); sy[i] = rnd_y(sx[i]); sm[i] = rnd_m();
    end
    begin
      int j;
      int k;
      int base;
      j = 0; k = 0; base = outs;
      while ((outs - base < 8) && k < 40) begin
        b32.out_ready = !(k >= 3 && k <= 5);
        b32.in_valid = (j < 8);
        if (j < 8) begin
          b32.x = sx[j]; b32.y = sy[j]; b32.mask = sm[j];
        end
        #1;
        if (k >= 3 && k <= 5)
          chk($sformatf("stall_in_ready%0d", k), 32'(b32.in_ready), 32'h0);
        if (b32.in_valid && b32.in_ready) j++;
        step();
        k++;
      end
      chk("stall_delivered", 32'(outs - base), 32'h8);
      chk("stall_accepted", 32'(j), 32'h8);
    end
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    step();

    // Reset with both stages full
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1;
    b32.x = 32'h5; b32.y = 32'h5; b32.mask = '1;
    step();
    b32.x = 32'h4;
    step();
    chk("pre_rst_v2", 32'(b32.out_valid), 32'h1);
    rst = 1'b1;
    b32.in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(b32.out_valid), 32'h0);
    chk("midrst_in_ready", 32'(b32.in_ready), 32'h1);
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("midrst_quiet%0d", i), 32'(b32.out_valid), 32'h0);
    end

    // Random traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      b32.in_valid = ($urandom_range(0, 3) != 0);
      b32.out_ready = ($urandom_range(0, 3) != 0);
      b32.x = $urandom();
      b32.y = rnd_y(b32.x);
      b32.mask = rnd_m();
      step();
    end
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    repeat (PIPE_STAGES + 3) step();
    chk("drain_empty", 32'(q.size()), 32'h0);

    // Padded last chunk (WIDTH=30)
    send30(32'h20000000, 32'h0, 32'hFFFFFFFF, "w30_bit29");
    chk("w30_fd29", 32'(b30.first_diff), 32'd29);
    send30(32'h3ABCDEF1, 32'h3ABCDEF1, 32'hFFFFFFFF, "w30_eq");
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = $urandom();
      send30(a, rnd_y(a), rnd_m(), $sformatf("w30_r%0d", i));
    end

`ifdef MATCH_COUNT_EN
    // Counter: 5 matches and 2 misses after a clear
    clr32 = 1'b1;
    step();
    clr32 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b32.x = 32'hA5A5A5A5;
      b32.y = (i < 5) ? 32'hA5A5A5A5 : 32'h0;
      b32.mask = '1;
      b32.in_valid = 1'b1;
      step();
      b32.in_valid = 1'b0;
      step();
    end
    step();
    chk("cnt_five", 32'(cnt32), 32'd5);
    // Clear coinciding with a z=1 transfer
    b32.y = 32'hA5A5A5A5;
    b32.in_valid = 1'b1;
    step();
    b32.in_valid = 1'b0;
    step();
    clr32 = 1'b1;
    step();
    clr32 = 1'b0;
    chk("cnt_clr_wins", 32'(cnt32), 32'h0);
    // Saturation with CNT_W=2
    clr30 = 1'b1;
    step();
    clr30 = 1'b0;
    for (int i = 0; i < 6; i++)
      send30(32'h1, 32'h1, 32'hFFFFFFFF, $sformatf("sat%0d", i));
    step();
    chk("cnt_sat", 32'(cnt30), 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
